memoria_responder: RTL
======================

// Module: memoria_responder
// PURPOSE
//  Memory-side responder for the accumulator processor's memory bus (mar / mdr / memory_write).
//  Holds program and data in a DEPTH x DATA_WIDTH array.
//  After reset it clears the array, then accepts a boot program over a valid/ready loader port.
//  In RUN state it serves CPU reads (asynchronous) and CPU writes (synchronous).
//  It holds the CPU in reset (cpu_hold) until the program is loaded.
// PARAMETERS
//  ADDR_WIDTH      8   address width; DEPTH = 2**ADDR_WIDTH = 256 words
//  DATA_WIDTH      16  word width; matches the accumulator and instruction width
//  CLEAR_ON_RESET  1   1: run the CLEAR state after reset; 0: go straight to LOAD, contents unchanged
// PORTS
//  clock       in   1   rising-edge clock
//  reset       in   1   asynchronous, active-low (0 = reset)
//  mar         in   8   CPU memory address
//  wr_data     in   16  CPU write data (driven from register_A)
//  memory_write in  1   CPU write strobe, active-high
//  mdr         out  16  read data = mem[mar] (combinational) in RUN; 0 otherwise
//  load_valid  in   1   loader word valid
//  load_data   in   16  loader word
//  load_last   in   1   qualifies the final loader word (sampled only when load_valid & load_ready)
//  load_ready  out  1   high only in LOAD state
//  cpu_hold    out  1   high in CLEAR and LOAD states; drives the CPU reset
//  wr_count    out  8   saturating count of accepted CPU writes since the last reset
// BEHAVIOUR
//  Reset (reset=0, async): state=CLEAR (LOAD if CLEAR_ON_RESET=0), ptr=0, wr_count=0,
//   load_ready=0, cpu_hold=1, mdr=0.
//   The array is not touched by reset itself.
//  CLEAR: one word per clock, mem[ptr]<=0 and ptr<=ptr+1.
//   When ptr==255 has been written, ptr wraps to 0 and state goes to LOAD.
//   CLEAR takes exactly 256 cycles.
//  LOAD: load_ready=1. On each edge with load_valid=1: mem[ptr]<=load_data, ptr<=ptr+1.
//   load_valid=0 means a stall: no write, ptr holds.
//   Leave LOAD for RUN after the accepted word has load_last=1,
//    or after the word written at ptr==255 (forced end, ptr wraps to 0).
//   Both conditions in the same cycle: a single transition to RUN.
//  RUN: load_ready=0, cpu_hold=0 (deasserts on the first edge in RUN).
//   load_* ports are ignored.
//   mdr = mem[mar], combinational, zero latency. The CPU samples it on the same edge it presents mar.
//   On an edge with memory_write=1: mem[mar]<=wr_data, and wr_count increments, saturating at 255.
//   Read-during-write to the same address: mdr shows old data in that cycle, new data from the next cycle.
//   X/Z on memory_write is treated as 0 (no write).
//  CPU writes (memory_write) are ignored in CLEAR and LOAD, and wr_count does not change.
//  RUN is terminal; only reset leaves it.
//  Reset mid-operation (any state): async return to the reset values above.
//   A partially cleared or partially loaded array keeps its contents, and the sequence restarts at ptr=0.
//  Widths: ptr is ADDR_WIDTH bits and wraps modulo DEPTH; no address is ever out of range.
// TESTING
//  T1 reset=0 for 3 cycles, release, CLEAR_ON_RESET=1
//   -> cpu_hold=1 and load_ready=0 for 256 cycles, then load_ready=1; a backdoor read of mem[0..255] returns all 0.
//  T2 LOAD words 16'h0205, 16'h0006, 16'h0800 (last=1), with load_valid low for 2 cycles between words
//   -> mem[0..2] hold those words, ptr stalls during the gaps, RUN on the edge after the third word,
//      cpu_hold falls, and mdr=16'h0205 while mar=0.
//  T3 In RUN: mar=8'h10, wr_data=16'hBEEF, memory_write=1 for 1 cycle
//   -> mdr shows the old value (0) in that cycle, 16'hBEEF on the next cycle, and wr_count=1.
//  T4 Stream 256 words with load_last=0
//   -> RUN entered after word 255, and mem[255] holds the last word.
//   A 257th valid word is ignored; mem[0] is unchanged.
//  T5 Assert reset=0 mid-LOAD at ptr=5
//   -> load_ready=0 and cpu_hold=1 immediately (async).
//   After release, CLEAR runs again and mem[0..4] read back 0.
//  T6 In RUN, 300 single-cycle writes
//   -> wr_count saturates at 255. memory_write=1 during CLEAR changes nothing.

Source files
------------

// File: rtl/memoria_responder.sv
// Memory-side responder for the accumulator processor bus: clears the array after reset,
// accepts a boot program over a valid/ready loader port, then serves CPU reads and writes.
module memoria_responder #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mar,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  memory_write,
  output logic [DATA_WIDTH-1:0] mdr,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  cpu_hold,
  output logic [7:0]            wr_count
);

  // state    | meaning
  // ST_CLEAR | zero one word per clock, ptr walks 0..DEPTH-1
  // ST_LOAD  | accept loader words at ptr until load_last or ptr wraps
  // ST_RUN   | CPU owns the array; terminal until reset
  typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_RUN} state_t;

  localparam int                    DEPTH       = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX     = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam state_t                RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_LOAD;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic [7:0]            wr_count_nxt;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= RESET_STATE;
      ptr      <= '0;
      wr_count <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      wr_count <= wr_count_nxt;
    end
  end

  // The array has no reset so contents survive a mid-sequence reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    wr_count_nxt = wr_count;
    mem_we       = 1'b0;
    mem_addr     = ptr;
    mem_wdata    = '0;
    load_ready   = 1'b0;
    cpu_hold     = 1'b1;
    mdr          = '0;
    case (state)
      ST_CLEAR: begin
        mem_we  = 1'b1;
        ptr_nxt = ptr + PTR_ONE;
        if (ptr == PTR_MAX) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_wdata = load_data;
          ptr_nxt   = ptr + PTR_ONE;
          if (load_last || ptr == PTR_MAX) state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        cpu_hold = 1'b0;
        mdr      = mem[mar];
        // An X strobe fails the if-test and is therefore treated as no write.
        if (memory_write) begin
          mem_we    = 1'b1;
          mem_addr  = mar;
          mem_wdata = wr_data;
          if (wr_count != 8'hFF) wr_count_nxt = wr_count + 8'd1;
        end
      end
      default: state_nxt = RESET_STATE;
    endcase
    // No array writes while reset is held, even though the clock may still run.
    if (!reset) mem_we = 1'b0;
  end

endmodule
